// File: rtl/xaddr_router_if.sv
//------------------------------------------------------------------------------
// Module   : xaddr_router_if
// Brief    : Master-side and slave-channel bus bundle for the xaddr_router.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface xaddr_router_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSLV   = 4
) ();
    logic [ADDR_W-1:0]      addr;
    logic                   sel;
    logic                   ready;
    logic [DATA_W-1:0]      data_to_rd;
    logic [NSLV-1:0]        slv_sel;
    logic [NSLV-1:0]        slv_ready;
    logic [NSLV*DATA_W-1:0] slv_data_flat;
    logic                   trap;
    logic                   trap_cause;
    logic                   trap_flag;
    logic [ADDR_W-1:0]      trap_addr;
    logic                   trap_clr;

    // Router-side view.
    modport slave (
        input  addr, sel, slv_ready, slv_data_flat, trap_clr,
        output ready, data_to_rd, slv_sel, trap, trap_cause, trap_flag, trap_addr
    );

    // System-side view: CPU data port plus the peripheral channels.
    modport master (
        output addr, sel, slv_ready, slv_data_flat, trap_clr,
        input  ready, data_to_rd, slv_sel, trap, trap_cause, trap_flag, trap_addr
    );
endinterface

`default_nettype wire

// File: rtl/xaddr_router.sv
//------------------------------------------------------------------------------
// Module   : xaddr_router
// Brief    : Registered base/size address router to NSLV slaves with trap on
//            unmapped access or slave timeout.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module xaddr_router #(
    parameter int                     ADDR_W  = 32,
    parameter int                     DATA_W  = 32,
    parameter int                     NSLV    = 4,
    parameter logic [NSLV*ADDR_W-1:0] BASE    = '0,
    parameter logic [NSLV*8-1:0]      SPAN_W  = {NSLV{8'd4}},
    parameter int                     TIMEOUT = 16,
    parameter int                     CNT_W   = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    xaddr_router_if.slave   bus
);

    localparam logic [CNT_W-1:0] c_TMO_LAST =
        (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2,
        S_TRAP   = 2'd3
    } state_t;

    state_t              r_state;
    logic [NSLV-1:0]     r_slv_sel;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ready;
    logic                r_trap;
    logic [DATA_W-1:0]   r_data;
    logic                r_pend_cause;
    logic                r_flag;
    logic                r_cause;
    logic [ADDR_W-1:0]   r_taddr;

    logic [NSLV-1:0]     w_hit;
    logic [NSLV-1:0]     w_hit_oh;
    logic                w_mapped;
    logic                w_slv_done;
    logic [DATA_W-1:0]   w_slv_data;

    for (genvar i = 0; i < NSLV; i++) begin : g_dec
        localparam logic [ADDR_W-1:0] c_MASK =
            ~((ADDR_W'(1) << SPAN_W[i*8 +: 8]) - ADDR_W'(1));
        assign w_hit[i] = ((bus.addr & c_MASK) == BASE[i*ADDR_W +: ADDR_W]);
    end

    // Isolating the lowest set bit gives lowest-index priority on overlap.
    assign w_hit_oh = w_hit & (~w_hit + NSLV'(1));
    assign w_mapped = |w_hit;

    // The latched one-hot select masks out ready from non-selected channels.
    assign w_slv_done = |(bus.slv_ready & r_slv_sel);

    always_comb begin
        w_slv_data = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (r_slv_sel[i]) begin
                w_slv_data = w_slv_data | bus.slv_data_flat[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_slv_sel    <= '0;
            r_cnt        <= '0;
            r_ready      <= 1'b0;
            r_trap       <= 1'b0;
            r_data       <= '0;
            r_pend_cause <= 1'b0;
            r_flag       <= 1'b0;
            r_cause      <= 1'b0;
            r_taddr      <= '0;
        end else begin
            r_ready <= 1'b0;
            r_trap  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.sel) begin
                        if (w_mapped) begin
                            r_slv_sel <= w_hit_oh;
                            r_cnt     <= '0;
                            r_state   <= S_ACCESS;
                        end else begin
                            r_pend_cause <= 1'b0;
                            r_ready      <= 1'b1;
                            r_trap       <= 1'b1;
                            r_data       <= '0;
                            r_state      <= S_TRAP;
                        end
                    end
                end
                S_ACCESS: begin
                    if (w_slv_done) begin
                        r_data    <= w_slv_data;
                        r_ready   <= 1'b1;
                        r_slv_sel <= '0;
                        r_state   <= S_DONE;
                    end else if ((TIMEOUT != 0) && (r_cnt == c_TMO_LAST)) begin
                        r_pend_cause <= 1'b1;
                        r_ready      <= 1'b1;
                        r_trap       <= 1'b1;
                        r_data       <= '0;
                        r_slv_sel    <= '0;
                        r_state      <= S_TRAP;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                S_TRAP: begin
                    // Only the first trap since the last clear is recorded.
                    if (!r_flag) begin
                        r_flag  <= 1'b1;
                        r_cause <= r_pend_cause;
                        r_taddr <= bus.addr;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            // Clear wins over a capture in the same cycle.
            if (bus.trap_clr) begin
                r_flag  <= 1'b0;
                r_cause <= 1'b0;
                r_taddr <= '0;
            end
        end
    end

    assign bus.slv_sel    = r_slv_sel;
    assign bus.ready      = r_ready;
    assign bus.trap       = r_trap;
    assign bus.data_to_rd = r_data;
    assign bus.trap_flag  = r_flag;
    assign bus.trap_cause = r_cause;
    assign bus.trap_addr  = r_taddr;

endmodule

`default_nettype wire
